id_ex_reg: RTL

//  ID/EX pipeline register. Captures decoded operands and control from ID and drives EX.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/fwd_sel_gen.sv | 25 ++
 rtl/id_ex_reg.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: forwarding select encodings, register-index helpers and the ID/EX control bundle.
package pipeline_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic [REG_IDX_W-1:0] rd;
    } id_ex_ctrl_t;

    // x0 is hardwired to zero, so a write to it never produces a dependency
    function automatic logic reg_hit(input logic [REG_IDX_W-1:0] x,
                                     input logic [REG_IDX_W-1:0] rd,
                                     input logic                 we);
        return we && (rd != REG_X0) && (x == rd);
    endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Forwarding select for one EX operand, computed from the ID-stage source register.
module fwd_sel_gen
    import pipeline_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 use_rs,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_we,
    input  logic [REG_IDX_W-1:0] mem_rd,
    input  logic                 mem_we,
    output logic [1:0]           sel
);

    // The EX occupant is the younger producer, so it shadows the MEM occupant
    always_comb begin
        sel = FWD_RF;
        if (use_rs) begin
            if (reg_hit(rs, ex_rd, ex_we))
                sel = FWD_EXMEM;
            else if (reg_hit(rs, mem_rd, mem_we))
                sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall and early forwarding-select generation.
// Optional ID_EX_PERF_CNT_EN adds saturating stall/flush event counters.
module id_ex_reg
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic [XLEN-1:0]      id_pc_i,
    input  logic [XLEN-1:0]      id_rs1_data_i,
    input  logic [XLEN-1:0]      id_rs2_data_i,
    input  logic [XLEN-1:0]      id_imm_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  logic                 id_use_rs1_i,
    input  logic                 id_use_rs2_i,
    input  logic                 id_reg_write_i,
    input  logic                 id_mem_read_i,
    input  logic                 id_mem_write_i,
    input  logic [CTRL_W-1:0]    id_ctrl_i,
    input  logic [REG_IDX_W-1:0] mem_rd_i,
    input  logic                 mem_reg_write_i,
    output logic                 id_stall_o,
    output logic                 ex_valid_o,
    output logic [XLEN-1:0]      ex_pc_o,
    output logic [XLEN-1:0]      ex_rs1_data_o,
    output logic [XLEN-1:0]      ex_rs2_data_o,
    output logic [XLEN-1:0]      ex_imm_o,
    output logic [REG_IDX_W-1:0] ex_rd_o,
    output logic                 ex_reg_write_o,
    output logic                 ex_mem_read_o,
    output logic                 ex_mem_write_o,
    output logic [CTRL_W-1:0]    ex_ctrl_o,
    output logic [1:0]           ex_fwd_a_sel_o,
    output logic [1:0]           ex_fwd_b_sel_o
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_flush_cnt_o
`endif
);

    id_ex_ctrl_t       ex_cb_p1;
    logic [XLEN-1:0]   ex_pc_p1;
    logic [XLEN-1:0]   ex_rs1_data_p1;
    logic [XLEN-1:0]   ex_rs2_data_p1;
    logic [XLEN-1:0]   ex_imm_p1;
    logic [CTRL_W-1:0] ex_ctrl_p1;
    logic [1:0]        ex_fwd_a_p1;
    logic [1:0]        ex_fwd_b_p1;

    logic        lu;
    logic        load_bubble;
    logic        ex_fwd_we;
    logic [1:0]  fwd_a_nxt;
    logic [1:0]  fwd_b_nxt;
    id_ex_ctrl_t id_cb;

    // A load in EX cannot forward until MEM, so a dependent instruction in ID must wait
    always_comb begin
        lu = id_valid_i && ex_cb_p1.valid && ex_cb_p1.mem_read &&
             ((id_use_rs1_i && reg_hit(id_rs1_i, ex_cb_p1.rd, 1'b1)) ||
              (id_use_rs2_i && reg_hit(id_rs2_i, ex_cb_p1.rd, 1'b1)));
    end

    assign id_stall_o  = rst_n && lu && !flush_i;
    assign load_bubble = flush_i || lu || !id_valid_i;
    assign ex_fwd_we   = ex_cb_p1.reg_write && ex_cb_p1.valid;

    assign id_cb = '{valid:     1'b1,
                     reg_write: id_reg_write_i,
                     mem_read:  id_mem_read_i,
                     mem_write: id_mem_write_i,
                     rd:        id_rd_i};

    fwd_sel_gen u_fwd_a (
        .rs     (id_rs1_i),
        .use_rs (id_use_rs1_i),
        .ex_rd  (ex_cb_p1.rd),
        .ex_we  (ex_fwd_we),
        .mem_rd (mem_rd_i),
        .mem_we (mem_reg_write_i),
        .sel    (fwd_a_nxt)
    );

    fwd_sel_gen u_fwd_b (
        .rs     (id_rs2_i),
        .use_rs (id_use_rs2_i),
        .ex_rd  (ex_cb_p1.rd),
        .ex_we  (ex_fwd_we),
        .mem_rd (mem_rd_i),
        .mem_we (mem_reg_write_i),
        .sel    (fwd_b_nxt)
    );

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cb_p1       <= '0;
            ex_pc_p1       <= '0;
            ex_rs1_data_p1 <= '0;
            ex_rs2_data_p1 <= '0;
            ex_imm_p1      <= '0;
            ex_ctrl_p1     <= '0;
            ex_fwd_a_p1    <= FWD_RF;
            ex_fwd_b_p1    <= FWD_RF;
        end else if (load_bubble) begin
            ex_cb_p1       <= '0;
            ex_pc_p1       <= '0;
            ex_rs1_data_p1 <= '0;
            ex_rs2_data_p1 <= '0;
            ex_imm_p1      <= '0;
            ex_ctrl_p1     <= '0;
            ex_fwd_a_p1    <= FWD_RF;
            ex_fwd_b_p1    <= FWD_RF;
        end else begin
            ex_cb_p1       <= id_cb;
            ex_pc_p1       <= id_pc_i;
            ex_rs1_data_p1 <= id_rs1_data_i;
            ex_rs2_data_p1 <= id_rs2_data_i;
            ex_imm_p1      <= id_imm_i;
            ex_ctrl_p1     <= id_ctrl_i;
            ex_fwd_a_p1    <= fwd_a_nxt;
            ex_fwd_b_p1    <= fwd_b_nxt;
        end
    end

    assign ex_valid_o     = ex_cb_p1.valid;
    assign ex_rd_o        = ex_cb_p1.rd;
    assign ex_reg_write_o = ex_cb_p1.reg_write;
    assign ex_mem_read_o  = ex_cb_p1.mem_read;
    assign ex_mem_write_o = ex_cb_p1.mem_write;
    assign ex_pc_o        = ex_pc_p1;
    assign ex_rs1_data_o  = ex_rs1_data_p1;
    assign ex_rs2_data_o  = ex_rs2_data_p1;
    assign ex_imm_o       = ex_imm_p1;
    assign ex_ctrl_o      = ex_ctrl_p1;
    assign ex_fwd_a_sel_o = ex_fwd_a_p1;
    assign ex_fwd_b_sel_o = ex_fwd_b_p1;

`ifdef ID_EX_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            perf_stall_cnt_o <= sat_inc(perf_stall_cnt_o, id_stall_o);
            perf_flush_cnt_o <= sat_inc(perf_flush_cnt_o, flush_i);
        end
    end
`endif

endmodule
